modexp_ctrl: RTL and testbench

Sequencer for square-and-multiply modular exponentiation. It sits above the Montgomery multiplier (MM) and acts as its initiator. It scans a 256-bit exponent MSB-first and issues one MM operation per exponent bit. Each operation is a square, followed by a multiply by the base when the bit is set. It drives the MM `en`/`pow_bit` handshake, captures `answer` on `end_flag`, and returns the final accumulator in the Montgomery domain.

---
 rtl/modexp_pkg.sv | 15 +
 rtl/exp_shifter.sv | 49 ++++
 rtl/modexp_ctrl.sv | 92 +++++++++
 tb/tb_modexp_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared constants and state encoding for the square-and-multiply sequencer.
package modexp_pkg;
    localparam int EXP_BITS = 256;
    localparam int IDX_W    = $clog2(EXP_BITS);
    localparam int MM_LAT   = 18;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        DROP,
        FINISH
    } state_t;
endpackage

// File: rtl/exp_shifter.sv
// Exponent shift register and bit index; leading-zero skipping is built in
// only when MODEXP_SKIP_LZ_EN is defined.
module exp_shifter
    import modexp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [EXP_BITS-1:0] exp_in,
    input  logic                adv,
    input  logic                scan,
    output logic                msb,
    output logic                nxt,
    output logic                last,
    output logic                scan_hold,
    output logic                exp_zero
);
`ifdef MODEXP_SKIP_LZ_EN
    localparam bit SKIP_LZ = 1'b1;
`else
    localparam bit SKIP_LZ = 1'b0;
`endif

    logic [EXP_BITS-1:0] sr;
    logic [IDX_W-1:0]    idx;
    logic                step;

    assign msb  = sr[EXP_BITS-1];
    assign nxt  = sr[EXP_BITS-2];
    assign last = (idx == '0);

    // A zero MSB at index 0 means every bit was zero: nothing left to issue.
    assign scan_hold = SKIP_LZ && scan && !msb && !last;
    assign exp_zero  = SKIP_LZ && !msb && last;
    assign step      = adv || scan_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= exp_in;
            idx <= IDX_W'(EXP_BITS - 1);
        end else if (step) begin
            sr  <= {sr[EXP_BITS-2:0], 1'b0};
            idx <= idx - IDX_W'(1);
        end
    end
endmodule

// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer driving a Montgomery multiplier, MSB-first.
// Define MODEXP_SKIP_LZ_EN to skip leading zero exponent bits in SCAN.
module modexp_ctrl
    import modexp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [EXP_BITS-1:0] base_m,
    input  logic [EXP_BITS-1:0] one_m,
    output logic                busy,
    output logic                done,
    output logic [EXP_BITS-1:0] result,
    output logic                mm_en,
    output logic                mm_pow_bit,
    output logic [EXP_BITS-1:0] mm_multiplicand,
    output logic [EXP_BITS-1:0] mm_indata,
    input  logic                mm_end_flag,
    input  logic [EXP_BITS-1:0] mm_answer
);
    state_t              state, state_nx;
    logic [EXP_BITS-1:0] acc, base_q, result_q;
    logic                msb, nxt, last, scan_hold, exp_zero;
    logic                load, adv;

    assign load = (state == IDLE) && start;
    assign adv  = (state == DROP) && !last;

    exp_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .exp_in    (exponent),
        .adv       (adv),
        .scan      (state == SCAN),
        .msb       (msb),
        .nxt       (nxt),
        .last      (last),
        .scan_hold (scan_hold),
        .exp_zero  (exp_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = SCAN;
            SCAN: begin
                if (scan_hold)     state_nx = SCAN;
                else if (exp_zero) state_nx = FINISH;
                else               state_nx = ISSUE;
            end
            ISSUE:  state_nx = WAIT;
            WAIT:   if (mm_end_flag) state_nx = DROP;
            DROP:   state_nx = last ? FINISH : ISSUE;
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            base_q   <= '0;
            result_q <= '0;
        end else begin
            if (load) begin
                acc    <= one_m;
                base_q <= base_m;
            end
            if ((state == WAIT) && mm_end_flag)
                acc <= mm_answer;
            if ((state_nx == FINISH) && (state != FINISH))
                result_q <= acc;
        end
    end

    assign busy            = (state != IDLE);
    assign done            = (state == FINISH);
    assign result          = result_q;
    assign mm_en           = (state == ISSUE) || (state == WAIT);
    // The shift happens at the end of DROP, so show the upcoming bit during
    // DROP to keep pow_bit settled a full cycle before mm_en rises.
    assign mm_pow_bit      = (state == DROP) ? nxt : msb;
    assign mm_multiplicand = acc;
    assign mm_indata       = base_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench: behavioural MM for n=97 plus a Fermat-based reference.
module tb_modexp_ctrl;
    import modexp_pkg::*;

    localparam int N = 97;

    logic                clk = 1'b0;
    logic                rst, start;
    logic [EXP_BITS-1:0] exponent, base_m, one_m;
    logic                busy, done, mm_en, mm_pow_bit, mm_end_flag;
    logic [EXP_BITS-1:0] result, mm_multiplicand, mm_indata, mm_answer;

    modexp_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .exponent        (exponent),
        .base_m          (base_m),
        .one_m           (one_m),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .mm_en           (mm_en),
        .mm_pow_bit      (mm_pow_bit),
        .mm_multiplicand (mm_multiplicand),
        .mm_indata       (mm_indata),
        .mm_end_flag     (mm_end_flag),
        .mm_answer       (mm_answer)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int rmod, rinv;

    int                  cnt = 0;
    logic                mdl_flag = 1'b0;
    logic [EXP_BITS-1:0] mdl_ans = '0;
    logic                stray_flag = 1'b0;
    logic [EXP_BITS-1:0] stray_ans = '0;
    bit                  op_bits[$];
    int                  stab_err = 0;
    logic                prev_pb = 1'b0;
    logic [EXP_BITS-1:0] prev_mc = '0, prev_ind = '0;

    logic [EXP_BITS-1:0] cur_e;
    int                  cur_b;

    assign mm_end_flag = mdl_flag | stray_flag;
    assign mm_answer   = stray_flag ? stray_ans : mdl_ans;

    function automatic int mont(input int a, input int b);
        return ((a * b) % N) * rinv % N;
    endfunction

    function automatic int powmod(input int b, input int e);
        int r = 1;
        repeat (e) r = r * b % N;
        return r;
    endfunction

    // N is prime and the base is coprime to it, so b^e == b^(e mod 96).
    function automatic int ref_result(input logic [EXP_BITS-1:0] e, input int b);
        int k;
        k = int'(e % 96);
        return powmod(b, k) * rmod % N;
    endfunction

    function automatic logic [EXP_BITS-1:0] rand_exp();
        logic [EXP_BITS-1:0] e;
        for (int i = 0; i < EXP_BITS / 32; i++) e[i*32 +: 32] = $urandom;
        return e;
    endfunction

    // MM model: one square (and multiply when pow_bit) per enable, answer after MM_LAT.
    always @(negedge clk) begin
        if (!mm_en) begin
            cnt      = 0;
            mdl_flag = 1'b0;
        end else begin
            if (cnt == 0) begin
                int a, r;
                a = int'(mm_multiplicand % N);
                r = mont(a, a);
                if (mm_pow_bit) r = mont(r, int'(mm_indata % N));
                mdl_ans = EXP_BITS'(r);
                op_bits.push_back(mm_pow_bit);
            end
            cnt++;
            mdl_flag = (cnt == MM_LAT + 1);
        end
        if (mm_en && (mm_pow_bit !== prev_pb || mm_multiplicand !== prev_mc ||
                      mm_indata !== prev_ind))
            stab_err++;
        prev_pb  = mm_pow_bit;
        prev_mc  = mm_multiplicand;
        prev_ind = mm_indata;
    end

    task automatic chk(input string tag, input logic [EXP_BITS-1:0] obs,
                       input logic [EXP_BITS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [EXP_BITS-1:0] e, input int b);
        cur_e    = e;
        cur_b    = b;
        exponent = e;
        base_m   = EXP_BITS'(b * rmod % N);
        one_m    = EXP_BITS'(rmod);
        op_bits.delete();
        stab_err = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_run(input string tag);
        int cyc = 0;
        int bad = 0;
        int first;
        while (done !== 1'b1 && cyc < 6000) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_result"}, result, EXP_BITS'(ref_result(cur_e, cur_b)));
        first = EXP_BITS - 1;
`ifdef MODEXP_SKIP_LZ_EN
        while (first >= 0 && cur_e[first] == 1'b0) first--;
`endif
        chk({tag, "_op_count"}, op_bits.size(), first + 1);
        for (int i = 0; i < op_bits.size() && i <= first; i++)
            if (op_bits[i] !== cur_e[first-i]) bad++;
        chk({tag, "_pow_seq"}, bad, 0);
        chk({tag, "_stable"}, stab_err, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_clear"}, busy, 0);
        chk({tag, "_result_hold"}, result, EXP_BITS'(ref_result(cur_e, cur_b)));
    endtask

    task automatic wait_ops(input string tag, input int n);
        int cyc = 0;
        while (!(op_bits.size() >= n && mm_en) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk({tag, "_reached"}, (op_bits.size() >= n && mm_en), 1);
    endtask

    initial begin
        logic [EXP_BITS-1:0] e, saved;
        int cyc, ndone;

        rmod = 1;
        repeat (EXP_BITS) rmod = rmod * 2 % N;
        rinv = 0;
        for (int x = 1; x < N; x++) if (rmod * x % N == 1) rinv = x;

        rst = 1'b1; start = 1'b0;
        exponent = '0; base_m = '0; one_m = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mm_en", mm_en, 0);
        chk("rst_pow_bit", mm_pow_bit, 0);
        chk("rst_result", result, 0);
        chk("rst_mcand", mm_multiplicand, 0);
        chk("rst_indata", mm_indata, 0);
        rst = 1'b0;
        tick();

        launch(EXP_BITS'(5), 3);
        finish_run("exp5");
        chk("exp5_const", result, EXP_BITS'(49 * rmod % N));

        launch('0, 5);
        finish_run("exp0");
        chk("exp0_one_m", result, EXP_BITS'(rmod));

        for (int k = 0; k < 3; k++) begin
            e = rand_exp() >> $urandom_range(0, 250);
            launch(e, $urandom_range(1, N - 1));
            finish_run("rand");
        end

        // Stray completion pulse in IDLE must not disturb anything.
        saved      = result;
        stray_ans  = rand_exp();
        stray_flag = 1'b1;
        tick();
        stray_flag = 1'b0;
        tick();
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_result", result, saved);
        chk("stray_idle_acc", mm_multiplicand, saved);

        // Stray completion pulse in DROP.
        e = rand_exp();
        e[EXP_BITS-1] = 1'b1;
        launch(e, $urandom_range(1, N - 1));
        cyc = 0;
        while (!(op_bits.size() >= 2 && !mm_en) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("drop_reached", (op_bits.size() >= 2 && !mm_en), 1);
        saved      = mm_multiplicand;
        stray_ans  = rand_exp();
        stray_flag = 1'b1;
        tick();
        stray_flag = 1'b0;
        chk("stray_drop_acc", mm_multiplicand, saved);
        finish_run("stray_drop");

        // start while busy, during the second operation.
        e = rand_exp();
        e[EXP_BITS-1] = 1'b1;
        launch(e, $urandom_range(1, N - 1));
        wait_ops("busy_start", 2);
        exponent = rand_exp();
        base_m   = EXP_BITS'($urandom_range(1, N - 1));
        start    = 1'b1;
        tick();
        start    = 1'b0;
        finish_run("busy_start");

        // Reset during WAIT of op 10, then a clean restart.
        e = rand_exp();
        e[EXP_BITS-1] = 1'b1;
        launch(e, $urandom_range(1, N - 1));
        wait_ops("rst_mid", 11);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_mm_en", mm_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_acc", mm_multiplicand, 0);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("rst_mid_no_done", ndone, 0);
        launch(rand_exp(), $urandom_range(1, N - 1));
        finish_run("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
